// File: rtl/dsram_responder_if.sv
// data_sram request/response bundle between the EXE-stage requester and the
// data-side SRAM responder.
interface dsram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        rdata_valid;

   modport master (
      output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata, rdata_valid
   );

   modport slave (
      input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
      output data_sram_rdata, rdata_valid
   );
endinterface

// File: rtl/dsram_responder.sv
// Data-side SRAM responder: byte-masked writes, fixed-latency word reads,
// and saturating read/write transaction counters.
module dsram_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              resetn,
   dsram_responder_if.slave  bus,
   output logic [31:0]       wr_cnt,
   output logic [31:0]       rd_cnt
);
   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned BYTES  = 4;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx_c;
   logic              wr_req_c;
   logic              rd_req_c;

   // Pipeline stage 0 is sampled at the request edge; the last stage is the output.
   logic [31:0]       stage_data [RD_LAT];
   logic              stage_vld  [RD_LAT];

   // Upper and lowest address bits are intentionally dropped (aliasing).
   logic              unused_addr_c;

   assign idx_c         = bus.data_sram_addr[ADDR_W+1:2];
   assign unused_addr_c = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};
   assign wr_req_c      = bus.data_sram_en && (bus.data_sram_we != 4'h0);
   assign rd_req_c      = bus.data_sram_en && (bus.data_sram_we == 4'h0);

   // Storage array: never reset, byte lanes selected by we only.
   always_ff @(posedge clk) begin
      if (wr_req_c) begin
         for (int i = 0; i < int'(BYTES); i++) begin
            if (bus.data_sram_we[i]) begin
               mem[idx_c][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline: each stage only loads when its upstream is valid, so the
   // final stage (rdata) holds its last value between read returns.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < int'(RD_LAT); k++) begin
            stage_vld[k]  <= 1'b0;
            stage_data[k] <= 32'h0;
         end
      end else begin
         stage_vld[0] <= rd_req_c;
         if (rd_req_c) begin
            stage_data[0] <= mem[idx_c];
         end
         for (int k = 1; k < int'(RD_LAT); k++) begin
            stage_vld[k] <= stage_vld[k-1];
            if (stage_vld[k-1]) begin
               stage_data[k] <= stage_data[k-1];
            end
         end
      end
   end

   assign bus.data_sram_rdata = stage_data[RD_LAT-1];
   assign bus.rdata_valid     = stage_vld[RD_LAT-1];

   // Saturating transaction counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_cnt <= 32'h0;
         rd_cnt <= 32'h0;
      end else begin
         if (wr_req_c && (wr_cnt != CNT_MAX)) begin
            wr_cnt <= wr_cnt + 32'd1;
         end
         if (rd_req_c && (rd_cnt != CNT_MAX)) begin
            rd_cnt <= rd_cnt + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder at RD_LAT 1, 3 and 2.
module tb_dsram_responder;
   logic        clk = 1'b0;
   logic        resetn1, resetn2, resetn3;
   logic [31:0] wr_cnt1, rd_cnt1, wr_cnt2, rd_cnt2, wr_cnt3, rd_cnt3;
   int          checks = 0;
   int          errors = 0;

   dsram_responder_if b1 ();
   dsram_responder_if b2 ();
   dsram_responder_if b3 ();

   dsram_responder #(.ADDR_W(10), .RD_LAT(1)) u1 (
      .clk(clk), .resetn(resetn1), .bus(b1.slave), .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1));
   dsram_responder #(.ADDR_W(10), .RD_LAT(2)) u2 (
      .clk(clk), .resetn(resetn2), .bus(b2.slave), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2));
   dsram_responder #(.ADDR_W(10), .RD_LAT(3)) u3 (
      .clk(clk), .resetn(resetn3), .bus(b3.slave), .wr_cnt(wr_cnt3), .rd_cnt(rd_cnt3));

   always #5 clk = ~clk;

   // Drive a request at a negedge, return at the next negedge.
   task automatic drv1(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      b1.data_sram_en = en; b1.data_sram_we = we; b1.data_sram_addr = a; b1.data_sram_wdata = d;
      @(negedge clk);
   endtask

   task automatic drv2(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      b2.data_sram_en = en; b2.data_sram_we = we; b2.data_sram_addr = a; b2.data_sram_wdata = d;
      @(negedge clk);
   endtask

   task automatic drv3(input logic en, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
      b3.data_sram_en = en; b3.data_sram_we = we; b3.data_sram_addr = a; b3.data_sram_wdata = d;
      @(negedge clk);
   endtask

   task automatic test_reset;
      resetn1 = 1'b0; resetn2 = 1'b0; resetn3 = 1'b0;
      b1.data_sram_en = 1'b0; b1.data_sram_we = 4'h0; b1.data_sram_addr = '0; b1.data_sram_wdata = '0;
      b2.data_sram_en = 1'b0; b2.data_sram_we = 4'h0; b2.data_sram_addr = '0; b2.data_sram_wdata = '0;
      b3.data_sram_en = 1'b0; b3.data_sram_we = 4'h0; b3.data_sram_addr = '0; b3.data_sram_wdata = '0;
      repeat (2) @(negedge clk);
      resetn1 = 1'b1; resetn2 = 1'b1; resetn3 = 1'b1;
      checks++;
      if (b1.data_sram_rdata !== 32'h0 || b1.rdata_valid !== 1'b0 || wr_cnt1 !== 32'h0 || rd_cnt1 !== 32'h0) begin
         errors++;
         $display("FAIL reset_u1 got rdata=%h vld=%b wr=%0d rd=%0d exp 0/0/0/0",
                  b1.data_sram_rdata, b1.rdata_valid, wr_cnt1, rd_cnt1);
      end
      checks++;
      if (b2.data_sram_rdata !== 32'h0 || b2.rdata_valid !== 1'b0 || wr_cnt2 !== 32'h0 || rd_cnt2 !== 32'h0) begin
         errors++;
         $display("FAIL reset_u2 got rdata=%h vld=%b wr=%0d rd=%0d exp 0/0/0/0",
                  b2.data_sram_rdata, b2.rdata_valid, wr_cnt2, rd_cnt2);
      end
      checks++;
      if (b3.data_sram_rdata !== 32'h0 || b3.rdata_valid !== 1'b0 || wr_cnt3 !== 32'h0 || rd_cnt3 !== 32'h0) begin
         errors++;
         $display("FAIL reset_u3 got rdata=%h vld=%b wr=%0d rd=%0d exp 0/0/0/0",
                  b3.data_sram_rdata, b3.rdata_valid, wr_cnt3, rd_cnt3);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({b1.rdata_valid, b2.rdata_valid, b3.rdata_valid} !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_valid cyc %0d got %b%b%b exp 000", c, b1.rdata_valid, b2.rdata_valid, b3.rdata_valid);
         end
      end
   endtask

   task automatic test_write_read;
      drv1(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      checks++;
      if (b1.rdata_valid !== 1'b0 || b1.data_sram_rdata !== 32'h0) begin
         errors++;
         $display("FAIL write_no_pulse got vld=%b rdata=%h exp 0/00000000", b1.rdata_valid, b1.data_sram_rdata);
      end
      drv1(1'b0, 4'hF, 32'h100, 32'h0);
      drv1(1'b1, 4'h0, 32'h100, 32'h0);
      checks++;
      if (b1.data_sram_rdata !== 32'hDEAD_BEEF || b1.rdata_valid !== 1'b1) begin
         errors++;
         $display("FAIL word_read got rdata=%h vld=%b exp deadbeef/1", b1.data_sram_rdata, b1.rdata_valid);
      end
      checks++;
      if (wr_cnt1 !== 32'd1 || rd_cnt1 !== 32'd1) begin
         errors++;
         $display("FAIL counters_1 got wr=%0d rd=%0d exp 1/1", wr_cnt1, rd_cnt1);
      end
      drv1(1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if (b1.rdata_valid !== 1'b0 || b1.data_sram_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL pulse_one_cycle got vld=%b rdata=%h exp 0/deadbeef", b1.rdata_valid, b1.data_sram_rdata);
      end
   endtask

   task automatic test_byte_mask;
      drv1(1'b1, 4'b0100, 32'h100, 32'h5555_5555);
      drv1(1'b1, 4'b0011, 32'h100, 32'h1234_1234);
      drv1(1'b1, 4'b0000, 32'h100, 32'h0);
      checks++;
      if (b1.data_sram_rdata !== 32'hDE55_1234 || b1.rdata_valid !== 1'b1) begin
         errors++;
         $display("FAIL byte_mask got rdata=%h vld=%b exp de551234/1", b1.data_sram_rdata, b1.rdata_valid);
      end
      checks++;
      if (wr_cnt1 !== 32'd3 || rd_cnt1 !== 32'd2) begin
         errors++;
         $display("FAIL counters_2 got wr=%0d rd=%0d exp 3/2", wr_cnt1, rd_cnt1);
      end
      drv1(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic test_alias;
      drv1(1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D);
      drv1(1'b1, 4'h0, 32'h0000_0006, 32'h0);
      checks++;
      if (b1.data_sram_rdata !== 32'hCAFE_F00D || b1.rdata_valid !== 1'b1) begin
         errors++;
         $display("FAIL alias got rdata=%h vld=%b exp cafef00d/1", b1.data_sram_rdata, b1.rdata_valid);
      end
      drv1(1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if (wr_cnt1 !== 32'd4 || rd_cnt1 !== 32'd3) begin
         errors++;
         $display("FAIL counters_3 got wr=%0d rd=%0d exp 4/3", wr_cnt1, rd_cnt1);
      end
   endtask

   task automatic test_pipelined;
      logic [31:0] exp_d [6];
      logic        exp_v [6];
      logic [31:0] rd_addr [6];
      logic        rd_en [6];
      exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_d = '{32'h0, 32'h0, 32'd1, 32'd2, 32'd3, 32'd3};
      rd_en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      rd_addr = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0};
      drv3(1'b1, 4'hF, 32'h0, 32'd1);
      drv3(1'b1, 4'hF, 32'h4, 32'd2);
      drv3(1'b1, 4'hF, 32'h8, 32'd3);
      for (int s = 0; s < 6; s++) begin
         drv3(rd_en[s], 4'h0, rd_addr[s], 32'h0);
         checks++;
         if (b3.rdata_valid !== exp_v[s] || b3.data_sram_rdata !== exp_d[s]) begin
            errors++;
            $display("FAIL pipe_step%0d got vld=%b rdata=%h exp %b/%h",
                     s, b3.rdata_valid, b3.data_sram_rdata, exp_v[s], exp_d[s]);
         end
      end
      checks++;
      if (wr_cnt3 !== 32'd3 || rd_cnt3 !== 32'd3) begin
         errors++;
         $display("FAIL pipe_counters got wr=%0d rd=%0d exp 3/3", wr_cnt3, rd_cnt3);
      end
   endtask

   task automatic test_reset_midflight;
      drv2(1'b1, 4'hF, 32'h20, 32'hA5A5_5A5A);
      b2.data_sram_en = 1'b1; b2.data_sram_we = 4'h0; b2.data_sram_addr = 32'h20;
      @(negedge clk);
      resetn2 = 1'b0;
      b2.data_sram_en = 1'b0;
      @(negedge clk);
      resetn2 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (b2.rdata_valid !== 1'b0 || b2.data_sram_rdata !== 32'h0 || rd_cnt2 !== 32'h0 || wr_cnt2 !== 32'h0) begin
            errors++;
            $display("FAIL midflight_discard cyc %0d got vld=%b rdata=%h rd=%0d wr=%0d exp 0/00000000/0/0",
                     c, b2.rdata_valid, b2.data_sram_rdata, rd_cnt2, wr_cnt2);
         end
         @(negedge clk);
      end
      drv2(1'b1, 4'h0, 32'h20, 32'h0);
      checks++;
      if (b2.rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat2_early got vld=%b exp 0", b2.rdata_valid);
      end
      drv2(1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if (b2.rdata_valid !== 1'b1 || b2.data_sram_rdata !== 32'hA5A5_5A5A || rd_cnt2 !== 32'd1) begin
         errors++;
         $display("FAIL mem_survives got vld=%b rdata=%h rd=%0d exp 1/a5a55a5a/1",
                  b2.rdata_valid, b2.data_sram_rdata, rd_cnt2);
      end
      drv2(1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if (b2.rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat2_single_pulse got vld=%b exp 0", b2.rdata_valid);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_write_read();
      test_byte_mask();
      test_alias();
      test_pipelined();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
